// File: rtl/bcd_subtractor.sv
// Digit-serial BCD subtractor: |a - b| in sign-magnitude, one digit per cycle,
// least significant digit first, with a ten's-complement pass for negative results.
module bcd_subtractor #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   diff,
    output logic                  negative,
    output logic                  error
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        NEG  = 2'd2,
        DONE = 2'd3
    } state_t;

    // One digit step: returns {borrow_out, digit}.
    function automatic logic [4:0] sub_digit(input logic [3:0] m, input logic [3:0] s,
                                             input logic bin);
        logic [4:0] t;
        t = {1'b0, m} - {1'b0, s} - {4'b0000, bin};
        if (t[4]) begin
            sub_digit = {1'b1, t[3:0] + 4'd10};
        end else begin
            sub_digit = {1'b0, t[3:0]};
        end
    endfunction

    function automatic logic has_bad_nibble(input logic [4*DIGITS-1:0] x);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (x[4*i +: 4] > 4'd9) begin
                bad = 1'b1;
            end else begin
                bad = bad;
            end
        end
        has_bad_nibble = bad;
    endfunction

    state_t               state_q, state_d;
    logic [4*DIGITS-1:0]  a_q, a_d, b_q, b_d, res_q, res_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 borrow_q, borrow_d;
    logic                 neg_q, neg_d;
    logic                 err_q, err_d;
    logic                 in_ready_q, in_ready_d;
    logic                 out_valid_q, out_valid_d;
    logic [3:0]           min_s, sub_s;
    logic [4:0]           dig_s;
    logic                 last_s;

    // Operand selection for the shared digit step (NEG negates the stored result).
    always_comb begin
        min_s  = a_q[{idx_q, 2'b00} +: 4];
        sub_s  = b_q[{idx_q, 2'b00} +: 4];
        if (state_q == NEG) begin
            min_s = 4'd0;
            sub_s = res_q[{idx_q, 2'b00} +: 4];
        end else begin
            min_s = min_s;
            sub_s = sub_s;
        end
        dig_s  = sub_digit(min_s, sub_s, borrow_q);
        last_s = (idx_q == IDX_W'(DIGITS - 1));
    end

    // Next-state and datapath update.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        idx_d    = idx_q;
        borrow_d = borrow_q;
        neg_d    = neg_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    a_d      = a;
                    b_d      = b;
                    res_d    = '0;
                    idx_d    = '0;
                    borrow_d = 1'b0;
                    neg_d    = 1'b0;
                    if (has_bad_nibble(a) || has_bad_nibble(b)) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        err_d   = 1'b0;
                        state_d = SUB;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            SUB, NEG: begin
                res_d[{idx_q, 2'b00} +: 4] = dig_s[3:0];
                if (last_s) begin
                    idx_d    = '0;
                    borrow_d = 1'b0;
                    // A final borrow in SUB means a < b: negate via a second pass.
                    if (state_q == SUB && dig_s[4]) begin
                        neg_d   = 1'b1;
                        state_d = NEG;
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    idx_d    = idx_q + IDX_W'(1);
                    borrow_d = dig_s[4];
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            idx_q       <= '0;
            borrow_q    <= 1'b0;
            neg_q       <= 1'b0;
            err_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            res_q       <= res_d;
            idx_q       <= idx_d;
            borrow_q    <= borrow_d;
            neg_q       <= neg_d;
            err_q       <= err_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign diff      = res_q;
    assign negative  = neg_q;
    assign error     = err_q;

endmodule

// File: tb/tb_bcd_subtractor.sv
// Directed table-driven bench for bcd_subtractor (DIGITS=4).
module tb_bcd_subtractor;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] diff;
    logic        negative;
    logic        error;

    int checks;
    int errors;

    bcd_subtractor #(.DIGITS(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .negative  (negative),
        .error     (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp_diff;
        logic        exp_neg;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Present operands at a negedge, return edges until out_valid (acceptance edge counts as 1).
    task automatic start_op(input logic [15:0] av, input logic [15:0] bv, output int lat);
        chk("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
        a        = av;
        b        = bv;
        in_valid = 1'b1;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        in_valid = 1'b0;
        a        = 16'hFFFF;
        b        = 16'hFFFF;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        if (!out_valid) chk("out_valid_timeout", {31'd0, out_valid}, 32'd1);
    endtask

    task automatic release_op();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("out_valid_after_release", {31'd0, out_valid}, 32'd0);
        chk("in_ready_after_release", {31'd0, in_ready}, 32'd1);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_diff"}, {16'd0, diff}, 32'd0);
        chk({tag, "_negative"}, {31'd0, negative}, 32'd0);
        chk({tag, "_error"}, {31'd0, error}, 32'd0);
    endtask

    initial begin
        int lat;
        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = 16'h0000;
        b         = 16'h0000;

        vecs[0] = '{16'h0042, 16'h0017, 16'h0025, 1'b0, 1'b0, 5};
        vecs[1] = '{16'h0017, 16'h0042, 16'h0025, 1'b1, 1'b0, 9};
        vecs[2] = '{16'h0000, 16'h9999, 16'h9999, 1'b1, 1'b0, 9};
        vecs[3] = '{16'h9999, 16'h0000, 16'h9999, 1'b0, 1'b0, 5};
        vecs[4] = '{16'h5050, 16'h5050, 16'h0000, 1'b0, 1'b0, 5};
        vecs[5] = '{16'h00A1, 16'h0001, 16'h0000, 1'b0, 1'b1, 1};
        vecs[6] = '{16'h1234, 16'h0567, 16'h0667, 1'b0, 1'b0, 5};
        vecs[7] = '{16'h0001, 16'h1000, 16'h0999, 1'b1, 1'b0, 9};
        vecs[8] = '{16'h0010, 16'h000F, 16'h0000, 1'b0, 1'b1, 1};
        vecs[9] = '{16'h8000, 16'h7999, 16'h0001, 1'b0, 1'b0, 5};

        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check_reset_values("reset");

        for (int i = 0; i < 10; i++) begin
            start_op(vecs[i].a, vecs[i].b, lat);
            chk($sformatf("v%0d_diff", i), {16'd0, diff}, {16'd0, vecs[i].exp_diff});
            chk($sformatf("v%0d_negative", i), {31'd0, negative}, {31'd0, vecs[i].exp_neg});
            chk($sformatf("v%0d_error", i), {31'd0, error}, {31'd0, vecs[i].exp_err});
            chk($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
            release_op();
        end

        // Hold DONE with out_ready low.
        start_op(16'h0042, 16'h0017, lat);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
            chk("hold_diff", {16'd0, diff}, 32'h0025);
            chk("hold_negative", {31'd0, negative}, 32'd0);
        end
        release_op();

        // Reset during the second SUB cycle discards the partial result.
        a        = 16'h0042;
        b        = 16'h0017;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check_reset_values("midsub_reset");
        start_op(16'h1000, 16'h0001, lat);
        chk("post_reset_diff", {16'd0, diff}, 32'h0999);
        chk("post_reset_negative", {31'd0, negative}, 32'd0);
        chk("post_reset_latency", lat, 5);
        release_op();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
